instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache.sv | 166 ++++++++++++++++
 tb/tb_instruction_cache.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// instruction_cache
//   Direct-mapped instruction cache with a byte-wide memory refill port.
//   Each entry holds one 32-bit word: the four bytes that start at the
//   halfword-aligned fetch address. A hit answers one cycle after the
//   request edge. A miss fetches four consecutive bytes over the memory
//   port, then answers six cycles after the request edge if the bus is
//   already granted.
//
//   Optional feature macro: ICACHE_STORAGE_EN
//     defined   -> valid/tag/word storage, hits and line fills.
//     undefined -> no storage; every request takes the miss path, with
//                  the same ports and timing.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   asking     in   fetch request strobe (one sampled edge = one request)
//   addr[31:0] in   fetch address (bit 0 ignored)
//   flush      in   abort any miss in flight and drop any pending answer
//   mem_grant  in   memory bus granted to this block
//   mem_din[7:0] in byte returned one cycle after mem_a is presented
//   data[31:0] out  {b3,b2,b1,b0} starting at the requested address
//   data_ready out  one-cycle pulse qualifying data
//   mem_a[31:0] out memory byte address
//   mem_rd     out  mem_a is a live read this cycle
module instruction_cache #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        asking,
  input  logic [31:0] addr,
  input  logic        flush,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output logic [31:0] data,
  output logic        data_ready,
  output logic [31:0] mem_a,
  output logic        mem_rd
);

  typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;   // latched, halfword-aligned miss address
  logic [2:0]  cnt_reg;    // READ step: 0..3 issue addresses, 1..4 capture bytes
  logic [31:0] line_reg;   // bytes shift in from the top; byte 0 ends at the bottom
  logic [31:0] req_addr;
  logic        hit;
  logic [31:0] resp_word;

  // Clearing bit 0 this way keeps every address bit referenced.
  assign req_addr = addr & 32'hFFFF_FFFE;

`ifdef ICACHE_STORAGE_EN
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 31 - INDEX_BITS;

  logic [ENTRIES-1:0]    valid_reg;
  logic [TAG_W-1:0]      tag_mem  [ENTRIES];
  logic [31:0]           word_mem [ENTRIES];
  logic [31:0]           word_rd_reg;
  logic                  resp_hit_reg;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic                  fill_done;

  assign req_index  = addr[INDEX_BITS:1];
  assign req_tag    = addr[31:INDEX_BITS+1];
  assign fill_index = addr_reg[INDEX_BITS:1];
  assign hit        = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
  // Last byte is on mem_din this cycle; a flush at the same edge discards the line.
  assign fill_done  = (state_reg == READ) && (cnt_reg == 3'd4) && !flush;

  // Only valid bits need reset; tag/word arrays stay plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= '0;
      resp_hit_reg <= 1'b0;
    end else begin
      if (fill_done) valid_reg[fill_index] <= 1'b1;
      // RESP is reached either from an IDLE hit or from a completed fill;
      // this flag remembers which source supplies the answer.
      resp_hit_reg <= (state_reg == IDLE) && asking && hit && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_index]  <= addr_reg[31:INDEX_BITS+1];
      word_mem[fill_index] <= {mem_din, line_reg[31:8]};
    end
    word_rd_reg <= word_mem[req_index];
  end

  assign resp_word = resp_hit_reg ? word_rd_reg : line_reg;
`else
  assign hit       = 1'b0;
  assign resp_word = line_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      line_reg   <= '0;
      data       <= '0;
      data_ready <= 1'b0;
      mem_a      <= '0;
      mem_rd     <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        mem_rd    <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (asking) begin
              if (hit) begin
                state_reg <= RESP;
              end else begin
                addr_reg <= req_addr;
                if (mem_grant) begin
                  state_reg <= READ;
                  mem_a     <= req_addr;
                  mem_rd    <= 1'b1;
                  cnt_reg   <= '0;
                end else begin
                  state_reg <= WAIT;
                end
              end
            end
          end
          WAIT: begin
            if (mem_grant) begin
              state_reg <= READ;
              mem_a     <= addr_reg;
              mem_rd    <= 1'b1;
              cnt_reg   <= '0;
            end
          end
          READ: begin
            // Addresses go out while cnt is 0..3; bytes come back one edge
            // later, so capture runs while cnt is 1..4.
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg < 3'd3) mem_a  <= mem_a + 32'd1;
            else                mem_rd <= 1'b0;
            if (cnt_reg != 3'd0) line_reg <= {mem_din, line_reg[31:8]};
            if (cnt_reg == 3'd4) state_reg <= RESP;
          end
          RESP: begin
            data       <= resp_word;
            data_ready <= 1'b1;
            state_reg  <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

`ifdef ICACHE_STORAGE_EN
  localparam bit STORAGE = 1'b1;
`else
  localparam bit STORAGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        asking = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        mem_grant = 1'b1;
  logic [7:0]  mem_din = '0;
  logic [31:0] data;
  logic        data_ready;
  logic [31:0] mem_a;
  logic        mem_rd;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [7:0]  mem_bytes [0:4095];

  instruction_cache dut (
    .clk(clk), .rst(rst), .asking(asking), .addr(addr), .flush(flush),
    .mem_grant(mem_grant), .mem_din(mem_din), .data(data),
    .data_ready(data_ready), .mem_a(mem_a), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory answers the address seen at an edge during the following cycle.
  always @(posedge clk) mem_din <= mem_bytes[mem_a[11:0]];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {mem_bytes[b + 12'd3], mem_bytes[b + 12'd2], mem_bytes[b + 12'd1], mem_bytes[b]};
  endfunction

  // Scoreboard consumer: every data_ready must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && data_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_data_ready: got data_ready=1 data=%h, required no response", data);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL response_data: got %h, required %h", data, e);
        end else begin
          $display("resp data=%h ok", data);
        end
      end
    end
  end

  // Issue one request; asking is raised immediately so consecutive calls
  // present the next request during the cycle data_ready is high.
  task automatic do_req(input logic [31:0] a, input int grant_low,
                        input bit exp_hit, input bit extra_ask);
    int  lat_exp, lat, rd_err, a_err;
    bit  seen, hit_path, exp_rd;
    hit_path = exp_hit && STORAGE;
    lat_exp  = hit_path ? 1 : 6 + grant_low;
    addr      = a;
    asking    = 1'b1;
    mem_grant = (grant_low == 0);
    sb_q.push_back(exp_word(a));
    seen = 0; lat = 0; rd_err = 0; a_err = 0;
    @(posedge clk); #1;
    if (!extra_ask) asking = 1'b0;
    else addr = a ^ 32'h0000_0040;
    for (int k = 0; k <= 20 && !seen; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 2) asking = 1'b0;
      if (grant_low > 0 && k == grant_low - 1) mem_grant = 1'b1;
      exp_rd = !hit_path && k >= grant_low && k <= grant_low + 3;
      if (mem_rd !== exp_rd) rd_err++;
      if (exp_rd && mem_a !== a + 32'(k - grant_low)) a_err++;
      if (data_ready === 1'b1) begin
        seen = 1;
        lat  = k;
      end
    end
    mem_grant = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL latency_timeout addr=%h: got no data_ready in 20 cycles, required latency %0d", a, lat_exp);
    end else if (lat != lat_exp) begin
      errors++;
      $display("FAIL latency addr=%h: got %0d cycles, required %0d", a, lat, lat_exp);
    end
    checks++;
    if (rd_err != 0) begin
      errors++;
      $display("FAIL mem_rd_pattern addr=%h: got %0d wrong cycles, required 0", a, rd_err);
    end
    if (!hit_path) begin
      checks++;
      if (a_err != 0) begin
        errors++;
        $display("FAIL mem_a_burst addr=%h: got %0d wrong addresses, required 0", a, a_err);
      end
      checks++;
      if (mem_a !== a + 32'd3) begin
        errors++;
        $display("FAIL mem_a_hold addr=%h: got %h, required %h", a, mem_a, a + 32'd3);
      end
    end
    $display("req addr=%h grant_low=%0d hit=%0d latency=%0d", a, grant_low, hit_path, lat);
  endtask

  task automatic idle_cycles(input int n);
    int rd_seen;
    rd_seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (mem_rd !== 1'b0) rd_seen++;
    end
    checks++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL idle_mem_rd: got mem_rd high in %0d cycles, required 0", rd_seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (data !== 32'h0)      begin errors++; $display("FAIL reset_data: got %h, required 0", data); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b, required 0", data_ready); end
    if (mem_a !== 32'h0)     begin errors++; $display("FAIL reset_mem_a: got %h, required 0", mem_a); end
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL reset_mem_rd: got %b, required 0", mem_rd); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_then_hit();
    do_req(32'h100, 0, 1'b0, 1'b0);
    do_req(32'h100, 0, 1'b1, 1'b0);   // presented while data_ready is high
    idle_cycles(3);
  endtask

  task automatic test_wait();
    do_req(32'h102, 3, 1'b0, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_flush();
    addr = 32'h200; asking = 1'b1; mem_grant = 1'b1;
    @(posedge clk); #1;
    asking = 1'b0;
    @(posedge clk); #1;               // second READ cycle
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL flush_mem_rd: got %b, required 0", mem_rd);
    end
    idle_cycles(10);
    $display("req addr=00000200 flushed");
    do_req(32'h200, 0, 1'b0, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_flush_and_ask();
    addr = 32'h300; asking = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    asking = 1'b0; flush = 1'b0;
    $display("req addr=00000300 dropped by flush");
    idle_cycles(10);
  endtask

  task automatic test_evict();
    do_req(32'h100, 0, 1'b0, 1'b0);
    do_req(32'h140, 0, 1'b0, 1'b0);
    do_req(32'h100, 0, 1'b0, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_ignore_and_wrap();
    do_req(32'h180, 0, 1'b0, 1'b1);
    idle_cycles(10);
    do_req(32'hFFFF_FFFE, 0, 1'b0, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_rst_mid_burst();
    addr = 32'h104; asking = 1'b1; mem_grant = 1'b1;
    @(posedge clk); #1;
    asking = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks += 3;
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL rst_mid_mem_rd: got %b, required 0", mem_rd); end
    if (mem_a !== 32'h0)     begin errors++; $display("FAIL rst_mid_mem_a: got %h, required 0", mem_a); end
    if (data !== 32'h0)      begin errors++; $display("FAIL rst_mid_data: got %h, required 0", data); end
    @(negedge clk) rst = 1'b0;
    $display("req addr=00000104 aborted by reset");
    idle_cycles(10);
    do_req(32'h100, 0, 1'b0, 1'b0);
    do_req(32'h104, 0, 1'b0, 1'b0);
    do_req(32'h100, 0, 1'b1, 1'b0);
    idle_cycles(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_bytes[i] = 8'((i * 37 + 91) & 255);
    mem_bytes[12'h100] = 8'h13;
    mem_bytes[12'h101] = 8'h05;
    mem_bytes[12'h102] = 8'h10;
    mem_bytes[12'h103] = 8'h00;

    test_reset();
    test_fill_then_hit();
    test_wait();
    test_flush();
    test_flush_and_ask();
    test_evict();
    test_ignore_and_wrap();
    test_rst_mid_burst();

    idle_cycles(5);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
